uart_rx: RTL and testbench

//  UART receiver: 8 data bits LSB-first, 1 stop bit, no parity, 16x-free mid-bit sampling.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync.sv | 31 +++
 rtl/uart_rx.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   state_t        - frame-level FSM states (3-bit encoding, debug-visible)
//   clks_per_bit() - clock cycles per serial bit for a given line rate / clock
//   UART_DATA_BITS - payload bits per frame
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    CLEANUP   = 3'd4
  } state_t;

  function automatic int clks_per_bit(input int baud, input int clk_f);
    return clk_f / baud;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for asynchronous inputs.
// Resets to all ones so an idle-high serial line does not look like a start bit
// coming out of reset.
// Ports:
//   clk  in  1      clock
//   rst  in  1      synchronous active-high reset
//   d    in  WIDTH  asynchronous input
//   q    out WIDTH  synchronized output (2-cycle latency)
module uart_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8 data bits LSB-first, 1 stop bit, no parity.
// Each bit is sampled once near its middle using a cycle counter, no 16x
// oversampling. Good bytes are delivered with a 1-cycle o_valid pulse; a stop
// bit sampled low discards the byte and pulses o_frame_err instead.
//
// Optional build macro UART_RX_MAJORITY_EN: when defined, every start/data/stop
// sample is the 2-of-3 majority of rx_s over the sample cycle and the two
// cycles before it. Timing is identical in both builds.
//
// Parameters:
//   BAUD   line rate in bit/s
//   CLK_F  clock frequency in Hz (CLK_F/BAUD must be >= 4)
// Ports:
//   clk          in   1  clock, all logic on posedge
//   rst          in   1  synchronous active-high reset
//   i_rx_serial  in   1  asynchronous serial line, idle high
//   o_rx_data    out  8  last correctly framed byte, held until the next good frame
//   o_valid      out  1  1-cycle pulse when o_rx_data is updated
//   o_frame_err  out  1  1-cycle pulse when the stop bit was sampled low
//   o_busy       out  1  high from start-bit detect until the FSM leaves the frame
//   t_state      out  3  current FSM state (debug)
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD  = 9600,
  parameter int CLK_F = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx_serial,
  output logic [7:0] o_rx_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy,
  output logic [2:0] t_state
);

  localparam int CLKS_PER_BIT = clks_per_bit(BAUD, CLK_F);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] HALF      = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(UART_DATA_BITS - 1);

  // Fewer than 4 clocks per bit leaves no room to find a bit centre.
  if (CLKS_PER_BIT < 4) begin : g_bad_rate
    $error("uart_rx: CLK_F/BAUD must be at least 4");
  end

  state_t                     state, state_next;
  logic [CNT_W-1:0]           counter, counter_next;
  logic [IDX_W-1:0]           bit_index, bit_index_next;
  logic [UART_DATA_BITS-1:0]  shift_reg, shift_next;
  logic [7:0]                 data_next;
  logic                       valid_next, err_next, busy_next;
  logic                       rx_s;
  logic                       sample;

  uart_sync #(.WIDTH(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (i_rx_serial),
    .q   (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // The two previous rx_s values plus the current one form the three-sample
  // window, so a single-cycle spike on the line cannot flip a sampled bit.
  logic [1:0] rx_hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_hist <= 2'b11;
    end else begin
      rx_hist <= {rx_hist[0], rx_s};
    end
  end

  assign sample = (rx_s & rx_hist[0]) | (rx_s & rx_hist[1]) | (rx_hist[0] & rx_hist[1]);
`else
  assign sample = rx_s;
`endif

  // State, timing and output registers; everything is computed in the
  // next-state block below so this process is a plain register bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      counter     <= '0;
      bit_index   <= '0;
      shift_reg   <= '0;
      o_rx_data   <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state       <= state_next;
      counter     <= counter_next;
      bit_index   <= bit_index_next;
      shift_reg   <= shift_next;
      o_rx_data   <= data_next;
      o_valid     <= valid_next;
      o_frame_err <= err_next;
      o_busy      <= busy_next;
    end
  end

  // Frame sequencing. The start bit is checked at its middle (HALF), which
  // puts every later sample, one full bit period apart, at a bit centre.
  // The stop bit is only sampled at its middle and CLEANUP lasts one cycle, so
  // the FSM is back in IDLE well before a back-to-back start bit arrives.
  always_comb begin
    state_next     = state;
    counter_next   = counter;
    bit_index_next = bit_index;
    shift_next     = shift_reg;
    data_next      = o_rx_data;
    valid_next     = 1'b0;
    err_next       = 1'b0;
    busy_next      = o_busy;

    case (state)
      IDLE: begin
        counter_next   = '0;
        bit_index_next = '0;
        if (!rx_s) begin
          state_next = START_BIT;
          busy_next  = 1'b1;
        end
      end

      START_BIT: begin
        if (counter == HALF) begin
          counter_next = '0;
          if (!sample) begin
            state_next = DATA_BITS;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_next = IDLE;
            busy_next  = 1'b0;
          end
        end else begin
          counter_next = counter + 1'b1;
        end
      end

      DATA_BITS: begin
        if (counter == LAST) begin
          counter_next          = '0;
          shift_next[bit_index] = sample;
          if (bit_index == LAST_INDEX) begin
            bit_index_next = '0;
            state_next     = STOP_BIT;
          end else begin
            bit_index_next = bit_index + 1'b1;
          end
        end else begin
          counter_next = counter + 1'b1;
        end
      end

      STOP_BIT: begin
        if (counter == LAST) begin
          counter_next = '0;
          state_next   = CLEANUP;
          busy_next    = 1'b0;
          if (sample) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end else begin
          counter_next = counter + 1'b1;
        end
      end

      CLEANUP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign t_state = state;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at 10 clocks per bit.
// Stimulus builds serial frames bit by bit from the byte value and pushes the
// expected pulse into a scoreboard queue; a negedge monitor pops and compares
// whenever the receiver pulses o_valid or o_frame_err.
module tb_uart_rx;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_rx_serial = 1'b1;
  logic [7:0] o_rx_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;
  logic [2:0] t_state;

  typedef struct {
    logic       frame_err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_held;
  int         checks = 0;
  int         errors = 0;

  uart_rx #(
    .BAUD  (100_000),
    .CLK_F (1_000_000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_rx_serial (i_rx_serial),
    .o_rx_data   (o_rx_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy),
    .t_state     (t_state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Record what the receiver should report for a full frame of this byte.
  task automatic expectFrame(input logic [7:0] data, input logic stop);
    exp_t e;
    if (stop) begin
      model_held  = data;
      e.frame_err = 1'b0;
    end else begin
      e.frame_err = 1'b1;
    end
    e.data = model_held;
    exp_q.push_back(e);
  endtask

  // Drive n_cycles of a frame: start bit, 8 data bits LSB first, stop bit,
  // each CPB clocks long. spike_at inverts the line for that one cycle.
  task automatic applyStimulus(input logic [7:0] data, input logic stop,
                               input int spike_at, input int n_cycles);
    int   bitpos;
    logic v;
    for (int c = 0; c < n_cycles; c++) begin
      bitpos = c / CPB;
      if (bitpos == 0)      v = 1'b0;
      else if (bitpos <= 8) v = data[bitpos-1];
      else                  v = stop;
      if (c == spike_at) v = ~v;
      i_rx_serial = v;
      @(posedge clk); #1;
    end
  endtask

  task automatic idleLine(input int n);
    i_rx_serial = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rx_data"}, o_rx_data, 0);
    checkOutput({tag, "_valid"}, o_valid, 0);
    checkOutput({tag, "_frame_err"}, o_frame_err, 0);
    checkOutput({tag, "_busy"}, o_busy, 0);
    checkOutput({tag, "_state"}, t_state, 0);
  endtask

  // Scoreboard monitor: every pulse must match the oldest outstanding frame.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (o_valid || o_frame_err)) begin
      checkOutput("pulse_exclusive", {31'd0, o_valid & o_frame_err}, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pulse: valid=%0b frame_err=%0b data=0x%0h, expected no pulse",
                 o_valid, o_frame_err, o_rx_data);
      end else begin
        e = exp_q.pop_front();
        checkOutput("pulse_is_frame_err", {31'd0, o_frame_err}, {31'd0, e.frame_err});
        checkOutput("rx_data", {24'd0, o_rx_data}, {24'd0, e.data});
      end
    end
  end

  initial begin : stimulus
    logic       busy_seen;
    logic [7:0] d;
    logic       stop;
    logic [7:0] exp6;
    exp_t       e6;

    rst = 1'b1;
    model_held = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst = 1'b0;
    idleLine(5);

    // Single good frame.
    expectFrame(8'hA5, 1'b1);
    applyStimulus(8'hA5, 1'b1, -1, 10 * CPB);
    idleLine(10);
    checkOutput("held_a5", o_rx_data, 8'hA5);

    // Back-to-back frames with a single stop bit between them.
    expectFrame(8'h00, 1'b1);
    applyStimulus(8'h00, 1'b1, -1, 10 * CPB);
    expectFrame(8'hFF, 1'b1);
    applyStimulus(8'hFF, 1'b1, -1, 10 * CPB);
    idleLine(10);
    checkOutput("held_ff", o_rx_data, 8'hFF);

    // Short low glitch while idle: busy rises briefly, no pulse follows.
    busy_seen = 1'b0;
    i_rx_serial = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      busy_seen |= o_busy;
    end
    i_rx_serial = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
      busy_seen |= o_busy;
    end
    checkOutput("glitch_busy_seen", busy_seen, 1);
    checkOutput("glitch_busy_clear", o_busy, 0);
    checkOutput("glitch_state_idle", t_state, 0);

    // Stop bit driven low: frame error, data keeps the previous good byte.
    expectFrame(8'h3C, 1'b0);
    applyStimulus(8'h3C, 1'b0, -1, 10 * CPB);
    idleLine(15);
    checkOutput("held_after_frame_err", o_rx_data, 8'hFF);

    // Reset for one cycle in the middle of the data bits aborts the frame.
    applyStimulus(8'h77, 1'b1, -1, 4 * CPB);
    i_rx_serial = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_held = 8'h00;
    checkResetValues("midframe_reset");
    idleLine(5);
    expectFrame(8'h5A, 1'b1);
    applyStimulus(8'h5A, 1'b1, -1, 10 * CPB);
    idleLine(10);
    checkOutput("held_5a", o_rx_data, 8'h5A);

    // One-cycle spike at the centre of data bit 3 (frame cycle 45).
`ifdef UART_RX_MAJORITY_EN
    exp6 = 8'h81;
`else
    exp6 = 8'h89;
`endif
    e6.frame_err = 1'b0;
    e6.data      = exp6;
    exp_q.push_back(e6);
    model_held = exp6;
    applyStimulus(8'h81, 1'b1, 4 * CPB + 5, 10 * CPB);
    idleLine(10);
    checkOutput("held_spike", o_rx_data, exp6);

    // Random frames; a bad stop bit is followed by enough idle line to let
    // the receiver settle from the low stop bit before the next start bit.
    for (int i = 0; i < 24; i++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
      expectFrame(d, stop);
      applyStimulus(d, stop, -1, 10 * CPB);
      if (stop) idleLine($urandom_range(0, 15));
      else      idleLine($urandom_range(12, 20));
    end
    idleLine(20);
    checkOutput("held_final", o_rx_data, model_held);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    checkOutput("final_idle", t_state, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
